// File: rtl/struct_packer_pkg.sv
// Shared types and helpers for the two-field packed-record assembler.
package struct_packer_pkg;

  typedef enum logic {SEL_FIELD0 = 1'b0, SEL_FIELD1 = 1'b1} field_sel_e;

  // Encoding matches the {have0, have1} flag pair.
  typedef enum logic [1:0] {ST_EMPTY, ST_HAVE1, ST_HAVE0, ST_FULL} pack_state_e;

  localparam int PARITY_MAX_W = 64;

  function automatic int width_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/struct_field_packer_if.sv
// Field-write and packed-word ports of struct_field_packer; out_parity exists only
// when STRUCT_PACKER_PARITY_EN is defined.
interface struct_field_packer_if
  import struct_packer_pkg::*;
#(
  parameter int FIELD0_WIDTH = 4,
  parameter int FIELD1_WIDTH = 4
);
  localparam int IN_WIDTH  = width_max(FIELD0_WIDTH, FIELD1_WIDTH);
  localparam int OUT_WIDTH = FIELD0_WIDTH + FIELD1_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sel;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
`ifdef STRUCT_PACKER_PARITY_EN
  logic                 out_parity;
`endif

  modport master (
`ifdef STRUCT_PACKER_PARITY_EN
    input  out_parity,
`endif
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
`ifdef STRUCT_PACKER_PARITY_EN
    output out_parity,
`endif
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/field_slot.sv
// One field register with its presence flag; load wins over clear.
module field_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] data_r;
  logic         valid_r;

  // Data and presence flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r  <= {W{1'b0}};
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= d;
      valid_r <= 1'b1;
    end else if (clear) begin
      valid_r <= 1'b0;
    end
  end

  assign q     = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/struct_field_packer.sv
// Assembles {field0, field1} from tagged field writes and offers the packed word
// under valid/ready. Define STRUCT_PACKER_PARITY_EN for a registered even-parity output.
module struct_field_packer
  import struct_packer_pkg::*;
#(
  parameter int FIELD0_WIDTH = 4,
  parameter int FIELD1_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  struct_field_packer_if.slave bus
);

  typedef struct packed {
    logic [FIELD0_WIDTH-1:0] field0;
    logic [FIELD1_WIDTH-1:0] field1;
  } packed_rec_t;

  logic [FIELD0_WIDTH-1:0] field0_q_s;
  logic [FIELD1_WIDTH-1:0] field1_q_s;
  logic [FIELD0_WIDTH-1:0] field0_d_s;
  logic [FIELD1_WIDTH-1:0] field1_d_s;
  logic                    have0_s;
  logic                    have1_s;
  logic                    load0_s;
  logic                    load1_s;
  logic                    clear0_s;
  logic                    clear1_s;
  logic                    out_valid_r;
  pack_state_e             state_s;
  pack_state_e             next_state_s;
  field_sel_e              sel_s;
  packed_rec_t             rec_s;

  assign field0_d_s = bus.in_data[FIELD0_WIDTH-1:0];
  assign field1_d_s = bus.in_data[FIELD1_WIDTH-1:0];
  assign sel_s      = field_sel_e'(bus.in_sel);
  assign state_s    = pack_state_e'({have0_s, have1_s});

  field_slot #(.W(FIELD0_WIDTH)) u_slot0 (
    .clk   (clk),
    .rst   (rst),
    .load  (load0_s),
    .clear (clear0_s),
    .d     (field0_d_s),
    .q     (field0_q_s),
    .valid (have0_s)
  );

  field_slot #(.W(FIELD1_WIDTH)) u_slot1 (
    .clk   (clk),
    .rst   (rst),
    .load  (load1_s),
    .clear (clear1_s),
    .d     (field1_d_s),
    .q     (field1_q_s),
    .valid (have1_s)
  );

  // Readiness depends on the downstream side only, so a full slot pair drains and refills in one cycle.
  assign bus.in_ready = (state_s != ST_FULL) | bus.out_ready;

  // Next-state and slot load/clear decode.
  always_comb begin
    load0_s      = 1'b0;
    load1_s      = 1'b0;
    clear0_s     = 1'b0;
    clear1_s     = 1'b0;
    next_state_s = state_s;
    case (state_s)
      ST_EMPTY, ST_HAVE0, ST_HAVE1: begin
        if (bus.in_valid) begin
          if (sel_s == SEL_FIELD0) begin
            load0_s      = 1'b1;
            next_state_s = pack_state_e'({1'b1, have1_s});
          end else begin
            load1_s      = 1'b1;
            next_state_s = pack_state_e'({have0_s, 1'b1});
          end
        end else begin
          next_state_s = state_s;
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            if (sel_s == SEL_FIELD0) begin
              load0_s      = 1'b1;
              clear1_s     = 1'b1;
              next_state_s = ST_HAVE0;
            end else begin
              load1_s      = 1'b1;
              clear0_s     = 1'b1;
              next_state_s = ST_HAVE1;
            end
          end else begin
            clear0_s     = 1'b1;
            clear1_s     = 1'b1;
            next_state_s = ST_EMPTY;
          end
        end else begin
          next_state_s = ST_FULL;
        end
      end
      default: begin
        next_state_s = ST_EMPTY;
      end
    endcase
  end

  // Packed-word valid flag, registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (next_state_s == ST_FULL);
    end
  end

  assign rec_s.field0  = field0_q_s;
  assign rec_s.field1  = field1_q_s;
  assign bus.out_data  = rec_s;
  assign bus.out_valid = out_valid_r;

`ifdef STRUCT_PACKER_PARITY_EN
  packed_rec_t next_rec_s;
  logic        parity_r;

  // Parity tracks the field registers themselves, so it always matches out_data.
  assign next_rec_s.field0 = load0_s ? field0_d_s : field0_q_s;
  assign next_rec_s.field1 = load1_s ? field1_d_s : field1_q_s;

  // Parity register, updated in step with the field registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= even_parity(PARITY_MAX_W'(next_rec_s));
    end
  end

  assign bus.out_parity = parity_r;
`endif

endmodule

// File: tb/tb_struct_field_packer.sv
// Directed self-checking bench for struct_field_packer with FIELD0_WIDTH=6, FIELD1_WIDTH=5.
module tb_struct_field_packer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  struct_field_packer_if #(.FIELD0_WIDTH(6), .FIELD1_WIDTH(5)) bus ();

  struct_field_packer #(.FIELD0_WIDTH(6), .FIELD1_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [10:0] exp);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
`ifdef STRUCT_PACKER_PARITY_EN
    chk({tag, "_parity"}, 32'(bus.out_parity), 32'(^exp));
`endif
  endtask

  // Drive a write at a falling edge; returns at the falling edge after acceptance.
  task automatic write_field(input string tag, input logic sel, input logic [5:0] data);
    int waits;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    #1;
    while (bus.in_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, "_ready_wait"}, 32'(waits), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'bx;
    bus.in_data  = 6'bxxxxxx;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 1'b0;
    bus.in_data   = 6'h00;
    bus.out_ready = 1'b0;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("por_out_valid", 32'(bus.out_valid), 32'd0);
    chk("por_out_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    #1;
    chk("por_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Basic pack
    bus.out_ready = 1'b1;
    write_field("basic_f0", 1'b0, 6'h2A);
    chk("basic_half_valid", 32'(bus.out_valid), 32'd0);
    write_field("basic_f1", 1'b1, 6'h13);
    check_word("basic", 11'b101010_10011);
    chk("basic_field0", 32'(bus.out_data[10:5]), 32'h2A);
    chk("basic_field1", 32'(bus.out_data[4:0]), 32'h13);
    @(negedge clk);
    chk("basic_consumed", 32'(bus.out_valid), 32'd0);

    // Overwrite keeps the last value
    write_field("ovw_f1a", 1'b1, 6'h01);
    chk("ovw_half_valid", 32'(bus.out_valid), 32'd0);
    write_field("ovw_f1b", 1'b1, 6'h1F);
    write_field("ovw_f0", 1'b0, 6'h00);
    check_word("ovw", 11'h01F);
    drain("ovw");

    // Backpressure with a held field0 write
    bus.out_ready = 1'b0;
    write_field("bp_f0", 1'b0, 6'h05);
    write_field("bp_f1", 1'b1, 6'h0A);
    check_word("bp_full", 11'h0AA);
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 6'h3C;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_stable", 32'(bus.out_data), 32'h0AA);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 6'bxxxxxx;
    chk("bp_have0_only", 32'(bus.out_valid), 32'd0);
    write_field("bp_f1b", 1'b1, 6'h07);
    check_word("bp_after", 11'h787);
    drain("bp");

    // Consume and write in the same cycle
    bus.out_ready = 1'b0;
    write_field("sim_f0", 1'b0, 6'h11);
    write_field("sim_f1", 1'b1, 6'h02);
    check_word("sim_full", 11'h222);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 1'b0;
    bus.in_data   = 6'h3F;
    #1;
    chk("sim_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 6'bxxxxxx;
    chk("sim_have0", 32'(bus.out_valid), 32'd0);
    write_field("sim_f1b", 1'b1, 6'h00);
    check_word("sim_word", 11'h7E0);
    drain("sim");

    // Truncation of in_data upper bits
    bus.out_ready = 1'b0;
    write_field("trunc_f1", 1'b1, 6'h3F);
    write_field("trunc_f0", 1'b0, 6'h01);
    check_word("trunc", 11'h03F);
    chk("trunc_field1", 32'(bus.out_data[4:0]), 32'h1F);

    // Asynchronous reset while FULL
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data", 32'(bus.out_data), 32'd0);
`ifdef STRUCT_PACKER_PARITY_EN
    chk("arst_parity", 32'(bus.out_parity), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    write_field("post_f0", 1'b0, 6'h05);
    chk("post_half_valid", 32'(bus.out_valid), 32'd0);
    write_field("post_f1", 1'b1, 6'h0A);
    check_word("post", 11'h0AA);
    drain("post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
